// File: rtl/shiftwindow_pkg.sv
// Shared constants for the shift-window statistics coprocessor.
//   Register word addresses, CTRL bit positions, and the window-sum width function.
package shiftwindow_pkg;

  localparam int unsigned A_PUSH   = 0;
  localparam int unsigned A_CTRL   = 1;
  localparam int unsigned A_SUM    = 2;
  localparam int unsigned A_MAX    = 3;
  localparam int unsigned A_MIN    = 4;
  localparam int unsigned A_MAXIDX = 5;
  localparam int unsigned A_THRESH = 6;
  localparam int unsigned A_HITS   = 7;
  localparam int unsigned A_TAP0   = 16;

  localparam int unsigned CTRL_CLRSTAT = 0;
  localparam int unsigned CTRL_FLUSH   = 1;

  // Wide enough to hold DEPTH samples of full-scale value without overflow.
  function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned depth);
    return data_w + $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shiftwindow_taps.sv
// Tap register chain for the sample window; tap 0 is the newest sample.
//   clk, reset   : clock, synchronous active-high reset
//   i_shift      : shift i_din into tap 0
//   i_flush      : synchronously zero every tap
//   o_taps       : all taps packed, tap i at [i*DATA_W +: DATA_W]
//   o_oldest     : tap DEPTH-1 (the sample leaving the window on the next shift)
module shiftwindow_taps
  import shiftwindow_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_shift,
  input  logic                      i_flush,
  input  logic [DATA_W-1:0]         i_din,
  output logic [DEPTH*DATA_W-1:0]   o_taps,
  output logic [DATA_W-1:0]         o_oldest
);

  logic [DEPTH-1:0][DATA_W-1:0] r_taps;

  // Taps start at zero, so the oldest tap reads 0 until the window has filled.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_taps <= '0;
    end else if (i_shift) begin
      r_taps <= {r_taps[DEPTH-2:0], i_din};
    end
  end

  assign o_taps   = r_taps;
  assign o_oldest = r_taps[DEPTH-1];

endmodule

// File: rtl/shiftwindow_stats_cp.sv
// Memory-mapped sliding-window statistics coprocessor (Avalon-MM slave, 0 wait states).
//   clk, reset       : clock, synchronous active-high reset
//   address          : word address (PUSH/CTRL/SUM/MAX/MIN/MAXIDX/THRESH/HITS, taps at 16+)
//   read / readdata  : read strobe, combinational read data
//   write / writedata / byteenable : write strobe, data, byte lanes (lane 0 qualifies PUSH)
module shiftwindow_stats_cp
  import shiftwindow_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic [31:0]       readdata,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable
);

  localparam int unsigned SUM_W  = sum_width(DATA_W, DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [SUM_W-1:0]        r_sum;
  logic [FILL_W-1:0]       r_fill;
  logic                    r_pending;
  logic [31:0]             r_samples;
  logic [SUM_W-1:0]        r_max;
  logic [SUM_W-1:0]        r_min;
  logic [31:0]             r_maxidx;
  logic [SUM_W-1:0]        r_thresh;
  logic [31:0]             r_hits;

  logic                    w_push;
  logic                    w_ctrl_wr;
  logic                    w_clr;
  logic                    w_flush;
  logic                    w_thresh_wr;
  logic [DATA_W-1:0]       w_din;
  logic [DATA_W-1:0]       w_oldest;
  logic [DEPTH*DATA_W-1:0] w_taps;
  logic [FILL_W-1:0]       w_new_fill;
  logic                    w_valid;
  logic                    w_unused;

  assign w_push      = write && (address == ADDR_W'(A_PUSH)) && byteenable[0];
  assign w_ctrl_wr   = write && (address == ADDR_W'(A_CTRL));
  assign w_clr       = w_ctrl_wr && writedata[CTRL_CLRSTAT];
  assign w_flush     = w_ctrl_wr && writedata[CTRL_FLUSH];
  assign w_thresh_wr = write && (address == ADDR_W'(A_THRESH));
  assign w_din       = writedata[DATA_W-1:0];
  assign w_valid     = (r_fill == FILL_W'(DEPTH));
  assign w_new_fill  = w_valid ? r_fill : r_fill + FILL_W'(1);
  assign w_unused    = ^{read, writedata, byteenable};

  shiftwindow_taps #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_taps (
    .clk      (clk),
    .reset    (reset),
    .i_shift  (w_push),
    .i_flush  (w_flush),
    .i_din    (w_din),
    .o_taps   (w_taps),
    .o_oldest (w_oldest)
  );

  // Window stage: incremental sum, fill level, push counter, and the pending flag
  // that hands each completed window to the stats stage exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum     <= '0;
      r_fill    <= '0;
      r_pending <= 1'b0;
      r_samples <= '0;
    end else begin
      if (w_flush) begin
        r_sum     <= '0;
        r_fill    <= '0;
        r_pending <= 1'b0;
      end else if (w_push) begin
        r_sum     <= r_sum + SUM_W'(w_din) - SUM_W'(w_oldest);
        r_fill    <= w_new_fill;
        r_pending <= (w_new_fill == FILL_W'(DEPTH));
      end else begin
        r_pending <= 1'b0;
      end
      if (w_push) begin
        r_samples <= r_samples + 32'd1;
      end
    end
  end

  // Stats stage: evaluates the registered sum one cycle after the window completes.
  // A clear or flush in the same cycle drops that window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_max    <= '0;
      r_min    <= '1;
      r_maxidx <= '0;
      r_hits   <= '0;
      r_thresh <= '0;
    end else begin
      if (w_clr) begin
        r_max    <= '0;
        r_min    <= '1;
        r_maxidx <= '0;
        r_hits   <= '0;
      end else if (r_pending && !w_flush) begin
        if (r_sum > r_max) begin
          r_max    <= r_sum;
          r_maxidx <= r_samples;
        end
        if (r_sum < r_min) begin
          r_min <= r_sum;
        end
        if ((r_sum > r_thresh) && (r_hits != '1)) begin
          r_hits <= r_hits + 32'd1;
        end
      end
      if (w_thresh_wr) begin
        r_thresh <= writedata[SUM_W-1:0];
      end
    end
  end

  // Read decode: zero-wait-state, zero-extended, unmapped addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_W'(A_PUSH):   readdata = r_samples;
      ADDR_W'(A_CTRL):   readdata = {16'd0, 8'(r_fill), 7'd0, w_valid};
      ADDR_W'(A_SUM):    readdata = 32'(r_sum);
      ADDR_W'(A_MAX):    readdata = 32'(r_max);
      ADDR_W'(A_MIN):    readdata = 32'(r_min);
      ADDR_W'(A_MAXIDX): readdata = r_maxidx;
      ADDR_W'(A_THRESH): readdata = 32'(r_thresh);
      ADDR_W'(A_HITS):   readdata = r_hits;
      default: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (address == ADDR_W'(A_TAP0 + i)) begin
            readdata = 32'(w_taps[i*DATA_W +: DATA_W]);
          end
        end
      end
    endcase
  end

endmodule
